reg_bank_load_ctrl: RTL and testbench
=====================================

Name: reg_bank_load_ctrl

Overview:
Sequences the loading of a bank of NUM_REGS falling-edge-captured data registers (filter/window registers) from a shared memory read port. On START it issues COUNT single-word reads at BASE_ADDR, BASE_ADDR+STRIDE, and so on. It steers each returned word to the matching register using a one-hot enable. It sits between the accelerator's top-level control FSM and the memory interface, and signals DONE when the bank is filled.

Parameters:
NUM_REGS, 8, number of target registers in the bank (≥2)
DATA_W, 32, data word width
ADDR_W, 16, memory address width
STRIDE, 1, address increment between consecutive words
IDX_W, clog2(NUM_REGS), width of the register index and of COUNT minus one

Ports:
CLK  in  1  clock; all controller state updates on the rising edge
RST  in  1  asynchronous, active-low reset
START  in  1  load request; sampled only in IDLE
BASE_ADDR  in  ADDR_W  first read address; latched when START is accepted
COUNT  in  IDX_W+1  number of words to load (0..NUM_REGS); latched when START is accepted
MEM_REQ  out  1  read request to the memory port
MEM_ADDR  out  ADDR_W  read address; valid while MEM_REQ=1
MEM_GNT  in  1  memory accepts the request in the current cycle
MEM_RVALID  in  1  read data valid
MEM_RDATA  in  DATA_W  read data
REG_EN  out  NUM_REGS  one-hot write enable to the register bank
REG_DIN  out  DATA_W  data to the register bank
BUSY  out  1  high in every state except IDLE
DONE  out  1  single-cycle completion pulse

Behaviour:
- Reset (RST=0, asynchronous): state=IDLE, index=0. MEM_REQ, REG_EN, BUSY and DONE are 0. MEM_ADDR and REG_DIN are 0. Reset mid-load abandons the load with no DONE. A returning MEM_RVALID after reset is ignored.
- States: IDLE, REQ, WAIT, WRITE, FIN.
- IDLE:
  - START=1 with COUNT in 1..NUM_REGS: latch BASE_ADDR and COUNT, set index=0, go to REQ.
  - START=1 with COUNT=0: go to FIN; no memory traffic.
  - COUNT>NUM_REGS: clamp to NUM_REGS.
- REQ: MEM_REQ=1, MEM_ADDR = latched_base + index*STRIDE (modulo 2^ADDR_W, wraps silently). Hold MEM_REQ and MEM_ADDR stable until MEM_GNT=1, then go to WAIT.
- WAIT: MEM_REQ=0. On MEM_RVALID=1, register MEM_RDATA into REG_DIN and go to WRITE. Unbounded wait.
- WRITE: REG_EN = one-hot(index) for exactly one cycle; REG_DIN is stable for the whole cycle.
  - REG_EN and REG_DIN come straight from rising-edge flops, so the target register captures on the falling edge of the same cycle.
  - index++. If the new index equals the latched COUNT, go to FIN; else go to REQ.
- FIN: DONE=1 for one cycle, BUSY=1, then go to IDLE.
- One outstanding read at a time. MEM_RVALID outside WAIT is ignored. MEM_GNT outside REQ is ignored.
- START, BASE_ADDR and COUNT are ignored while BUSY=1. START in the cycle DONE is high is also ignored; START is next accepted in IDLE.
- REG_EN is all-zero in every state except WRITE. No register is written twice per load. Registers with index ≥ COUNT are never written.
- Minimum per-word latency, with MEM_GNT in the first REQ cycle and MEM_RVALID the cycle after: 3 cycles (REQ, WAIT, WRITE).

Test Plan:
- Reset then idle: RST=0 pulsed mid-cycle -> all outputs 0 immediately. With START=0 for 20 cycles, MEM_REQ and REG_EN stay 0.
- Basic load: COUNT=3, BASE_ADDR=0x0100, MEM_GNT tied 1, MEM_RVALID one cycle after grant with data 0xA0,0xA1,0xA2 -> MEM_ADDR 0x0100,0x0101,0x0102. REG_EN pulses 0x01,0x02,0x04 with REG_DIN 0xA0,0xA1,0xA2. DONE is high exactly once, 10 cycles after the START cycle. BUSY is high throughout.
- Stalls: MEM_GNT delayed 4 cycles and MEM_RVALID delayed 6 cycles per word, COUNT=NUM_REGS=8 -> MEM_ADDR held stable during the stall. REG_EN walks 0x01..0x80 with no gaps or duplicates. One DONE.
- Boundaries:
  - COUNT=0 -> DONE in the cycle after START; MEM_REQ never asserted.
  - COUNT=9 -> clamped to 8 writes.
  - BASE_ADDR=0xFFFE with STRIDE=1 -> addresses 0xFFFE, 0xFFFF, 0x0000.
- Protocol robustness:
  - START and a new BASE_ADDR pulsed mid-load -> ignored; addresses are unchanged.
  - Spurious MEM_RVALID in REQ -> no REG_EN.
  - START in the DONE cycle -> not accepted.
- Reset mid-operation: RST=0 during WAIT of word 2 -> immediate IDLE with no DONE. A later MEM_RVALID produces no REG_EN. A fresh START with COUNT=2 then completes normally.

Source files
------------

// File: rtl/reg_bank_load_ctrl.sv
// Loads a bank of falling-edge-captured registers from a shared single-word memory read port.
// One read is outstanding at a time; every output is driven straight from a rising-edge flop.
module reg_bank_load_ctrl #(
   parameter int NUM_REGS = 8,
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 16,
   parameter int STRIDE   = 1,
   parameter int IDX_W    = $clog2(NUM_REGS)
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                START,
   input  logic [ADDR_W-1:0]   BASE_ADDR,
   input  logic [IDX_W:0]      COUNT,
   output logic                MEM_REQ,
   output logic [ADDR_W-1:0]   MEM_ADDR,
   input  logic                MEM_GNT,
   input  logic                MEM_RVALID,
   input  logic [DATA_W-1:0]   MEM_RDATA,
   output logic [NUM_REGS-1:0] REG_EN,
   output logic [DATA_W-1:0]   REG_DIN,
   output logic                BUSY,
   output logic                DONE
);

   localparam int CW = IDX_W + 1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ   = 3'd1,
      S_WAIT  = 3'd2,
      S_WRITE = 3'd3,
      S_FIN   = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [CW-1:0]       idx_q, idx_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [ADDR_W-1:0]   ptr_q, ptr_d;
   logic [DATA_W-1:0]   din_q, din_d;
   logic                req_q, req_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [NUM_REGS-1:0] en_q, en_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic [CW-1:0]       cnt_clamp_s;

   function automatic logic [NUM_REGS-1:0] onehot(input logic [CW-1:0] idx);
      logic [NUM_REGS-1:0] v;
      v = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         v[i] = (idx == CW'(i));
      end
      return v;
   endfunction

   assign cnt_clamp_s = (COUNT > CW'(NUM_REGS)) ? CW'(NUM_REGS) : COUNT;

   // Next-state, datapath and next-output decode.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      din_d   = din_q;
      case (state_q)
         S_IDLE: begin
            if (START) begin
               if (cnt_clamp_s == {CW{1'b0}}) begin
                  state_d = S_FIN;
               end else begin
                  state_d = S_REQ;
                  cnt_d   = cnt_clamp_s;
                  idx_d   = {CW{1'b0}};
                  ptr_d   = BASE_ADDR;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_REQ: begin
            if (MEM_GNT) begin
               state_d = S_WAIT;
            end else begin
               state_d = S_REQ;
            end
         end
         S_WAIT: begin
            if (MEM_RVALID) begin
               din_d   = MEM_RDATA;
               state_d = S_WRITE;
            end else begin
               state_d = S_WAIT;
            end
         end
         S_WRITE: begin
            idx_d = idx_q + CW'(1);
            ptr_d = ptr_q + ADDR_W'(STRIDE);
            if (idx_d == cnt_q) begin
               state_d = S_FIN;
            end else begin
               state_d = S_REQ;
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Outputs are decoded from the next state so they leave the flops aligned with it.
      req_d  = (state_d == S_REQ);
      addr_d = req_d ? ptr_d : {ADDR_W{1'b0}};
      en_d   = (state_d == S_WRITE) ? onehot(idx_q) : {NUM_REGS{1'b0}};
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_FIN);
   end

   // State, datapath and output registers.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         ptr_q   <= '0;
         din_q   <= '0;
         req_q   <= 1'b0;
         addr_q  <= '0;
         en_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         din_q   <= din_d;
         req_q   <= req_d;
         addr_q  <= addr_d;
         en_q    <= en_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign MEM_REQ  = req_q;
   assign MEM_ADDR = addr_q;
   assign REG_EN   = en_q;
   assign REG_DIN  = din_q;
   assign BUSY     = busy_q;
   assign DONE     = done_q;

endmodule

// File: tb/tb_reg_bank_load_ctrl.sv
// Directed bench for reg_bank_load_ctrl: a bench-side memory responder with programmable
// grant/data delays, a negedge monitor logging requests, writes and DONE, and hand-computed expectations.
module tb_reg_bank_load_ctrl;

   logic        CLK, RST, START;
   logic [15:0] BASE_ADDR;
   logic [3:0]  COUNT;
   logic        MEM_REQ;
   logic [15:0] MEM_ADDR;
   logic        MEM_GNT, MEM_RVALID;
   logic [31:0] MEM_RDATA;
   logic [7:0]  REG_EN;
   logic [31:0] REG_DIN;
   logic        BUSY, DONE;

   int total, bad;
   int cyc, start_cyc, done_cyc, done_cnt, n_req, n_wr, addr_unstable, busy_drop;
   bit req_seen, busy_watch, prev_req, force_rv, spur;
   logic [15:0] prev_addr;
   int gnt_dly, rv_dly, phase, rcnt, widx;
   logic [31:0] data_base;
   logic [15:0] addr_log [16];
   logic [7:0]  en_log [16];
   logic [31:0] din_log [16];

   reg_bank_load_ctrl dut (
      .CLK(CLK), .RST(RST), .START(START), .BASE_ADDR(BASE_ADDR), .COUNT(COUNT),
      .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR), .MEM_GNT(MEM_GNT), .MEM_RVALID(MEM_RVALID),
      .MEM_RDATA(MEM_RDATA), .REG_EN(REG_EN), .REG_DIN(REG_DIN), .BUSY(BUSY), .DONE(DONE)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic clr();
      n_req = 0; n_wr = 0; done_cnt = 0; req_seen = 1'b0; addr_unstable = 0;
      busy_drop = 0; busy_watch = 1'b0; phase = 0; rcnt = 0; widx = 0;
   endtask

   // One clock: sample outputs at the falling edge, then drive the memory side for the next rising edge.
   task automatic step();
      @(negedge CLK);
      cyc++;
      if (MEM_REQ) begin
         req_seen = 1'b1;
         if (!prev_req) begin
            if (n_req < 16) addr_log[n_req] = MEM_ADDR;
            n_req++;
         end else if (MEM_ADDR !== prev_addr) begin
            addr_unstable++;
         end
      end
      prev_req  = MEM_REQ;
      prev_addr = MEM_ADDR;
      if (REG_EN != 8'h00) begin
         if (n_wr < 16) begin
            en_log[n_wr]  = REG_EN;
            din_log[n_wr] = REG_DIN;
         end
         n_wr++;
      end
      if (busy_watch && !BUSY) busy_drop++;
      if (DONE) begin
         done_cnt++;
         done_cyc   = cyc;
         busy_watch = 1'b0;
      end
      MEM_GNT    = 1'b0;
      MEM_RVALID = 1'b0;
      if (!RST) begin
         phase = 0;
         rcnt  = 0;
      end else if (force_rv) begin
         MEM_RVALID = 1'b1;
         MEM_RDATA  = 32'hBAD0;
      end else if (phase == 0) begin
         if (MEM_REQ) begin
            if (rcnt == gnt_dly) begin
               MEM_GNT = 1'b1;
               phase   = 1;
               rcnt    = 0;
            end else begin
               rcnt++;
               if (spur) begin
                  MEM_RVALID = 1'b1;
                  MEM_RDATA  = 32'hDEAD;
               end
            end
         end
      end else begin
         if (rcnt == rv_dly) begin
            MEM_RVALID = 1'b1;
            MEM_RDATA  = data_base + 32'(widx);
            widx++;
            phase = 0;
            rcnt  = 0;
         end else begin
            rcnt++;
         end
      end
   endtask

   task automatic start_load(input logic [15:0] base, input logic [3:0] cnt);
      start_cyc = cyc;
      START = 1'b1; BASE_ADDR = base; COUNT = cnt;
      step();
      START = 1'b0; BASE_ADDR = 16'h0000; COUNT = 4'h0;
      busy_watch = 1'b1;
   endtask

   task automatic run_done(input string tag, input int budget);
      for (int i = 0; i < budget && done_cnt == 0; i++) step();
      chk_eq({tag, "_timeout"}, 64'(done_cnt > 0), 64'd1);
      for (int i = 0; i < 3; i++) step();
   endtask

   initial begin
      total = 0; bad = 0; cyc = 0; done_cyc = 0; start_cyc = 0;
      RST = 1'b1; START = 1'b0; BASE_ADDR = 16'h0; COUNT = 4'h0;
      MEM_GNT = 1'b0; MEM_RVALID = 1'b0; MEM_RDATA = 32'h0;
      prev_req = 1'b0; prev_addr = 16'h0; force_rv = 1'b0; spur = 1'b0;
      gnt_dly = 0; rv_dly = 0; data_base = 32'h0;
      clr();

      // Reset pulse mid-cycle, then idle
      #3 RST = 1'b0;
      #1 chk_eq("rst_outs", 64'({MEM_REQ, MEM_ADDR, REG_EN, REG_DIN, BUSY, DONE}), 64'd0);
      @(negedge CLK);
      RST = 1'b1;
      clr();
      for (int i = 0; i < 20; i++) step();
      chk_eq("idle_req", 64'(req_seen), 64'd0);
      chk_eq("idle_wr", 64'(n_wr), 64'd0);

      // Basic load, zero-wait memory
      clr(); gnt_dly = 0; rv_dly = 0; data_base = 32'hA0;
      start_load(16'h0100, 4'd3);
      run_done("basic", 40);
      chk_eq("basic_nreq", 64'(n_req), 64'd3);
      chk_eq("basic_nwr", 64'(n_wr), 64'd3);
      for (int i = 0; i < 3; i++) begin
         chk_eq($sformatf("basic_addr%0d", i), 64'(addr_log[i]), 64'(16'h0100 + 16'(i)));
         chk_eq($sformatf("basic_en%0d", i), 64'(en_log[i]), 64'(8'h01 << i));
         chk_eq($sformatf("basic_din%0d", i), 64'(din_log[i]), 64'(32'hA0 + 32'(i)));
      end
      chk_eq("basic_done_cnt", 64'(done_cnt), 64'd1);
      chk_eq("basic_latency", 64'(done_cyc - start_cyc), 64'd10);
      chk_eq("basic_busy", 64'(busy_drop), 64'd0);

      // Grant and data stalls, full bank
      clr(); gnt_dly = 4; rv_dly = 6; data_base = 32'h10;
      start_load(16'h2000, 4'd8);
      run_done("stall", 300);
      chk_eq("stall_addr_stable", 64'(addr_unstable), 64'd0);
      chk_eq("stall_nreq", 64'(n_req), 64'd8);
      chk_eq("stall_nwr", 64'(n_wr), 64'd8);
      for (int i = 0; i < 8; i++) begin
         chk_eq($sformatf("stall_en%0d", i), 64'(en_log[i]), 64'(8'h01 << i));
         chk_eq($sformatf("stall_din%0d", i), 64'(din_log[i]), 64'(32'h10 + 32'(i)));
      end
      chk_eq("stall_addr7", 64'(addr_log[7]), 64'h2007);
      chk_eq("stall_done_cnt", 64'(done_cnt), 64'd1);

      // COUNT=0: immediate DONE, no traffic
      clr(); gnt_dly = 0; rv_dly = 0;
      start_load(16'h0005, 4'd0);
      run_done("zero", 10);
      chk_eq("zero_latency", 64'(done_cyc - start_cyc), 64'd1);
      chk_eq("zero_req", 64'(req_seen), 64'd0);
      chk_eq("zero_wr", 64'(n_wr), 64'd0);

      // COUNT=9 clamps to 8
      clr(); data_base = 32'h50;
      start_load(16'h0000, 4'd9);
      run_done("clamp", 60);
      chk_eq("clamp_nwr", 64'(n_wr), 64'd8);
      chk_eq("clamp_en7", 64'(en_log[7]), 64'h80);
      chk_eq("clamp_done_cnt", 64'(done_cnt), 64'd1);

      // Address wrap
      clr(); data_base = 32'h60;
      start_load(16'hFFFE, 4'd3);
      run_done("wrap", 40);
      chk_eq("wrap_a0", 64'(addr_log[0]), 64'hFFFE);
      chk_eq("wrap_a1", 64'(addr_log[1]), 64'hFFFF);
      chk_eq("wrap_a2", 64'(addr_log[2]), 64'h0000);

      // START with a new BASE_ADDR mid-load is ignored
      clr(); gnt_dly = 2; rv_dly = 2; data_base = 32'h70;
      start_load(16'h0300, 4'd4);
      for (int i = 0; i < 3; i++) step();
      START = 1'b1; BASE_ADDR = 16'h0700; COUNT = 4'd2;
      step();
      START = 1'b0; BASE_ADDR = 16'h0000; COUNT = 4'd0;
      run_done("midstart", 100);
      chk_eq("midstart_nwr", 64'(n_wr), 64'd4);
      for (int i = 0; i < 4; i++)
         chk_eq($sformatf("midstart_addr%0d", i), 64'(addr_log[i]), 64'(16'h0300 + 16'(i)));
      chk_eq("midstart_done_cnt", 64'(done_cnt), 64'd1);

      // Spurious RVALID while requesting
      clr(); gnt_dly = 3; rv_dly = 0; spur = 1'b1; data_base = 32'h80;
      start_load(16'h0400, 4'd2);
      run_done("spur", 60);
      spur = 1'b0;
      chk_eq("spur_nwr", 64'(n_wr), 64'd2);
      chk_eq("spur_din0", 64'(din_log[0]), 64'h80);
      chk_eq("spur_din1", 64'(din_log[1]), 64'h81);
      chk_eq("spur_en1", 64'(en_log[1]), 64'h02);

      // START in the DONE cycle is not accepted
      clr(); gnt_dly = 0; rv_dly = 0;
      start_load(16'h0600, 4'd1);
      for (int i = 0; i < 30 && done_cnt == 0; i++) step();
      chk_eq("findone_timeout", 64'(done_cnt > 0), 64'd1);
      START = 1'b1; BASE_ADDR = 16'h0800; COUNT = 4'd2;
      req_seen = 1'b0;
      step();
      START = 1'b0; BASE_ADDR = 16'h0000; COUNT = 4'd0;
      for (int i = 0; i < 10; i++) step();
      chk_eq("findone_req", 64'(req_seen), 64'd0);
      chk_eq("findone_busy", 64'(BUSY), 64'd0);
      chk_eq("findone_done_cnt", 64'(done_cnt), 64'd1);

      // Reset during WAIT of the second word
      clr(); gnt_dly = 0; rv_dly = 5; data_base = 32'h90;
      start_load(16'h0A00, 4'd3);
      for (int i = 0; i < 40 && !(n_req == 2 && !MEM_REQ); i++) step();
      chk_eq("midrst_reach", 64'(n_req), 64'd2);
      #2 RST = 1'b0;
      #1 chk_eq("midrst_outs", 64'({MEM_REQ, MEM_ADDR, REG_EN, REG_DIN, BUSY, DONE}), 64'd0);
      step();
      RST = 1'b1;
      force_rv = 1'b1;
      for (int i = 0; i < 3; i++) step();
      force_rv = 1'b0;
      for (int i = 0; i < 3; i++) step();
      chk_eq("midrst_nwr", 64'(n_wr), 64'd1);
      chk_eq("midrst_nodone", 64'(done_cnt), 64'd0);
      clr(); gnt_dly = 0; rv_dly = 0; data_base = 32'hC0;
      start_load(16'h0500, 4'd2);
      run_done("after_rst", 40);
      chk_eq("after_rst_nwr", 64'(n_wr), 64'd2);
      chk_eq("after_rst_en0", 64'(en_log[0]), 64'h01);
      chk_eq("after_rst_en1", 64'(en_log[1]), 64'h02);
      chk_eq("after_rst_din1", 64'(din_log[1]), 64'hC1);
      chk_eq("after_rst_a1", 64'(addr_log[1]), 64'h0501);
      chk_eq("after_rst_latency", 64'(done_cyc - start_cyc), 64'd7);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
